sdram_port_scheduler: RTL
=========================

SDRAM_PORT_SCHEDULER -- requirements
Module: sdram_port_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ASIZE, 22, SDRAM word-address width.
- LSIZE, 9, burst-length width.
- TIMEOUT, 1023, maximum cycles from START to DONE before abort.
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, controller clock.
- RESET_N, in, 1, reset; asynchronous, active-low.
- REQ, in, 4, per-port service request; bit0=RD1, bit1=RD2, bit2=WR1, bit3=WR2.
- LOAD, in, 4, per-port register load and FIFO clear.
- BASE, in, 4*ASIZE, packed per-port start address; port i uses bits [i*ASIZE +: ASIZE].
- MAX, in, 4*ASIZE, packed per-port wrap limit.
- LENGTH, in, 4*LSIZE, packed per-port burst length.
- REF_PENDING, in, 1, refresh pending; blocks new grants.
- DONE, in, 1, one-cycle transfer-complete pulse from the command sequencer.
- GRANT, out, 4, one-hot active port.
- START, out, 1, one-cycle transfer launch pulse.
- RW, out, 1, transfer direction; 1=write (ports 2,3), 0=read (ports 0,1).
- ADDR, out, ASIZE, burst start address.
- BLEN, out, LSIZE, burst length.
- ERR, out, 1, one-cycle timeout pulse.

Function
REQ-003 The block SHALL hold per-port registers cur_addr[i] (ASIZE bits) and len[i] (LSIZE bits).
REQ-004 LOAD[i] high at a CLK edge SHALL load cur_addr[i]<=BASE[i] and len[i]<=LENGTH[i]; LOAD takes priority over every other update to port i.
REQ-005 Port i SHALL be eligible when REQ[i]=1, LOAD[i]=0 and len[i]!=0.
REQ-006 The FSM SHALL have exactly three states: IDLE, BUSY and RECOVER.
REQ-007 IDLE: if REF_PENDING=0 and any port is eligible, then at the next edge the FSM SHALL select the winner, set GRANT, ADDR=cur_addr, BLEN=len, RW, pulse START for one cycle, clear the watchdog, and go to BUSY.
REQ-008 Winner selection SHALL be round-robin: search starts at port ptr and ascends modulo 4; the first eligible port wins.
REQ-009 BUSY: GRANT, ADDR, BLEN and RW SHALL hold stable; the watchdog SHALL increment every cycle.
REQ-010 DONE in BUSY with no LOAD on the granted port g SHALL update cur_addr[g]: if cur_addr[g] < MAX[g]-len[g], then cur_addr[g]+len[g]; else BASE[g].
REQ-011 The comparison and addition in REQ-010 SHALL be unsigned at ASIZE width, with no carry beyond ASIZE.
REQ-012 DONE in BUSY SHALL, at that edge, clear GRANT, set ptr<=(g+1) mod 4, and return the FSM to IDLE.
REQ-013 LOAD[g] coinciding with DONE SHALL apply the LOAD and skip the REQ-010 advance; GRANT still ends.
REQ-014 LOAD[g] during BUSY without DONE SHALL reload registers only; the transfer continues until DONE.
REQ-015 Watchdog reaching TIMEOUT in BUSY SHALL pulse ERR, clear GRANT, leave cur_addr[g] unchanged, set ptr<=(g+1) mod 4, and go to RECOVER.
REQ-016 RECOVER SHALL last exactly one cycle and then go to IDLE; DONE arriving in IDLE or RECOVER SHALL be ignored.
REQ-017 At least one IDLE cycle SHALL separate consecutive grants; START-to-START minimum is 2 cycles after DONE.
REQ-018 REF_PENDING SHALL gate only the IDLE-to-BUSY transition; it SHALL NOT abort a transfer in BUSY.
REQ-019 Changes on REQ while in BUSY SHALL NOT alter the current grant.

Reset
REQ-020 RESET_N low SHALL asynchronously force: state=IDLE, ptr=0, GRANT=0, START=0, RW=0, ADDR=0, BLEN=0, ERR=0, watchdog=0, all cur_addr=0, all len=128.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no address update; after release, the first grant SHALL NOT come before the second CLK edge.

Verification
REQ-022 The bench SHALL cover:
- LOAD all ports (BASE=0x1000*i, LENGTH=128), REQ=4'b1111, DONE 10 cycles after each START -> grant order 0,1,2,3,0; RW 0,0,1,1.
- Port 0 BASE=0, MAX=256, LEN=128; three transfers -> ADDR 0, 128, 0 (wrap).
- REQ=4'b0001 with REF_PENDING=1 for 20 cycles -> no START; START one cycle after REF_PENDING falls.
- No DONE after START with TIMEOUT=1023 -> ERR pulse 1023 cycles after START, GRANT=0, ADDR unchanged on the next grant.
- LOAD[g] on the same edge as DONE with BASE=0x2000 -> next grant of g gives ADDR=0x2000.
- RESET_N low during BUSY -> all outputs at reset values immediately; no address advance.

Source files
------------

// File: rtl/sdram_port_scheduler_if.sv
// Port-request and grant bundle between the SDRAM front end and the port scheduler.
interface sdram_port_scheduler_if #(
  parameter int unsigned ASIZE = 22,
  parameter int unsigned LSIZE = 9
);
  logic [3:0]         REQ;
  logic [3:0]         LOAD;
  logic [4*ASIZE-1:0] BASE;
  logic [4*ASIZE-1:0] MAX;
  logic [4*LSIZE-1:0] LENGTH;
  logic               REF_PENDING;
  logic               DONE;
  logic [3:0]         GRANT;
  logic               START;
  logic               RW;
  logic [ASIZE-1:0]   ADDR;
  logic [LSIZE-1:0]   BLEN;
  logic               ERR;

  modport master (
    output REQ, LOAD, BASE, MAX, LENGTH, REF_PENDING, DONE,
    input  GRANT, START, RW, ADDR, BLEN, ERR
  );

  modport slave (
    input  REQ, LOAD, BASE, MAX, LENGTH, REF_PENDING, DONE,
    output GRANT, START, RW, ADDR, BLEN, ERR
  );
endinterface

// File: rtl/sdram_port_scheduler.sv
// Round-robin scheduler for two read and two write SDRAM ports with per-port
// wrapping address pointers and a transfer watchdog.
module sdram_port_scheduler #(
  parameter int unsigned ASIZE   = 22,
  parameter int unsigned LSIZE   = 9,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic                    CLK,
  input logic                    RESET_N,
  sdram_port_scheduler_if.slave  bus
);

  localparam int unsigned NPORT = 4;
  localparam int unsigned WDW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RECOVER} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       g_q, g_d;
  logic             armed_q;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [3:0]       grant_q, grant_d;
  logic             start_q, start_d;
  logic             rw_q, rw_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [LSIZE-1:0] blen_q, blen_d;
  logic             err_q, err_d;

  logic [ASIZE-1:0] base_a   [NPORT];
  logic [ASIZE-1:0] max_a    [NPORT];
  logic [LSIZE-1:0] length_a [NPORT];
  logic [ASIZE-1:0] cur_addr [NPORT];
  logic [LSIZE-1:0] len      [NPORT];

  logic [3:0]       elig;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic             found;
  logic             launch;
  logic             done_ev;
  logic             timeout_hit;
  logic [ASIZE-1:0] len_ext;
  logic [ASIZE-1:0] wrap_lim;
  logic [ASIZE-1:0] adv_addr;

  // Unpack the per-port configuration buses
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
    assign base_a[gi]   = bus.BASE[gi*ASIZE +: ASIZE];
    assign max_a[gi]    = bus.MAX[gi*ASIZE +: ASIZE];
    assign length_a[gi] = bus.LENGTH[gi*LSIZE +: LSIZE];
  end

  // Round-robin search from ptr over eligible ports
  always_comb begin
    elig  = '0;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      elig[i] = bus.REQ[i] & ~bus.LOAD[i] & (len[i] != '0);
    end
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign launch      = (state_q == S_IDLE) && armed_q && !bus.REF_PENDING && found;
  assign done_ev     = (state_q == S_BUSY) && bus.DONE;
  assign timeout_hit = (wd_q == WDW'(TIMEOUT - 1));

  // Next burst address of the granted port; wraps to BASE at the limit
  always_comb begin
    len_ext  = ASIZE'(len[g_q]);
    wrap_lim = max_a[g_q] - len_ext;
    adv_addr = (cur_addr[g_q] < wrap_lim) ? (cur_addr[g_q] + len_ext) : base_a[g_q];
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE takes precedence over a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (launch) state_d = S_BUSY;
      S_BUSY: begin
        if (bus.DONE)         state_d = S_IDLE;
        else if (timeout_hit) state_d = S_RECOVER;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    grant_d = grant_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    blen_d  = blen_q;
    wd_d    = wd_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          grant_d = 4'(1) << win;
          start_d = 1'b1;
          rw_d    = win[1];
          addr_d  = cur_addr[win];
          blen_d  = len[win];
          wd_d    = '0;
          g_d     = win;
        end
      end
      S_BUSY: begin
        wd_d = wd_q + WDW'(1);
        if (bus.DONE) begin
          grant_d = '0;
          ptr_d   = g_q + 2'(1);
        end else if (timeout_hit) begin
          grant_d = '0;
          err_d   = 1'b1;
          ptr_d   = g_q + 2'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and control; armed_q delays the first grant after reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q   <= '0;
      g_q     <= '0;
      armed_q <= 1'b0;
      wd_q    <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      blen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      armed_q <= 1'b1;
      wd_q    <= wd_d;
      grant_q <= grant_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      blen_q  <= blen_d;
      err_q   <= err_d;
    end
  end

  // Per-port address/length registers; LOAD overrides the post-DONE advance
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        cur_addr[i] <= '0;
        len[i]      <= LSIZE'(128);
      end
    end else begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (bus.LOAD[i]) begin
          cur_addr[i] <= base_a[i];
          len[i]      <= length_a[i];
        end else if (done_ev && (g_q == 2'(i))) begin
          cur_addr[i] <= adv_addr;
        end
      end
    end
  end

  assign bus.GRANT = grant_q;
  assign bus.START = start_q;
  assign bus.RW    = rw_q;
  assign bus.ADDR  = addr_q;
  assign bus.BLEN  = blen_q;
  assign bus.ERR   = err_q;

endmodule
